// File: rtl/sigcapture_pkg.sv
// sigcapture_pkg: shared defaults and types for the circular sample recorder.
package sigcapture_pkg;

  // Default geometry: 512 samples of 8 bits.
  localparam int DEF_A_WIDTH = 9;
  localparam int DEF_D_WIDTH = 8;
  localparam int DEPTH       = 1 << DEF_A_WIDTH;

  // Fill counter for the default geometry; one extra bit so it can hold DEPTH.
  typedef logic [DEF_A_WIDTH:0] fill_t;

  // Number of entries addressed by an aw-bit pointer.
  function automatic int unsigned depth_of(input int aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/sigcapture_ram2port.sv
// ram2port: simple dual-port RAM, one synchronous write port and one
// synchronous read port on the same clock. A read that hits the address
// being written in the same cycle returns the previous contents.
// Contents are never reset.
module ram2port #(
  parameter int A_WIDTH = 9,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [A_WIDTH-1:0] i_waddr,
  input  logic [D_WIDTH-1:0] i_wdata,
  input  logic               i_re,
  input  logic [A_WIDTH-1:0] i_raddr,
  output logic [D_WIDTH-1:0] o_rdata
);

  localparam int NWORDS = 1 << A_WIDTH;

  logic [D_WIDTH-1:0] r_mem [NWORDS];
  logic [D_WIDTH-1:0] r_rdata;

  // Write port: store the sample when enabled.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read port: nonblocking read samples the array before this edge's write,
  // which gives read-old-on-collision. Output holds while not enabled.
  always_ff @(posedge clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sigcapture.sv
// sigcapture: circular-buffer sample recorder with a programmable read-back
// delay. Each strobe writes one sample and returns the sample recorded
// 'offset' strobes earlier (offset 0 = a full buffer lap).
// Optional feature macro: SIGCAPTURE_FREEZE_EN adds a 'freeze' input that
// stops writes so the captured buffer replays cyclically.
module sigcapture
  import sigcapture_pkg::*;
#(
  parameter int A_WIDTH = DEF_A_WIDTH,
  parameter int D_WIDTH = DEF_D_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [D_WIDTH-1:0] din,
  input  logic [A_WIDTH-1:0] offset,
`ifdef SIGCAPTURE_FREEZE_EN
  input  logic               freeze,
`endif
  output logic [D_WIDTH-1:0] dout,
  output logic               dout_valid,
  output logic               full
);

  localparam int unsigned       DEPTH_I  = depth_of(A_WIDTH);
  localparam logic [A_WIDTH:0]  FILL_MAX = DEPTH_I[A_WIDTH:0];

  logic [A_WIDTH-1:0] r_wr_addr;
  logic [A_WIDTH:0]   r_fill;
  logic               r_dout_valid;

  logic               w_freeze;
  logic               w_wr_en;
  logic [A_WIDTH:0]   w_delay;
  logic               w_rd_ok;
  logic [A_WIDTH-1:0] w_raddr;
  logic [D_WIDTH-1:0] w_rdata;

`ifdef SIGCAPTURE_FREEZE_EN
  assign w_freeze = freeze;
`else
  assign w_freeze = 1'b0;
`endif

  // A frozen strobe still advances the pointer and reads; it only skips the write.
  assign w_wr_en = en & ~w_freeze;

  // Effective delay in strobes; offset 0 means a whole lap.
  assign w_delay = (offset == '0) ? FILL_MAX : {1'b0, offset};

  // Data is trustworthy only if at least 'delay' samples were written since reset.
  assign w_rd_ok = (w_delay <= r_fill);

  // Read pointer trails the write pointer, modulo buffer depth.
  assign w_raddr = r_wr_addr - offset;

  ram2port #(
    .A_WIDTH (A_WIDTH),
    .D_WIDTH (D_WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_addr),
    .i_wdata (din),
    .i_re    (en),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Write pointer: free-running, advances on every strobe (frozen or not).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    r_wr_addr <= '0;
    else if (en) r_wr_addr <= r_wr_addr + 1'b1;
  end

  // Fill counter: counts real writes, saturating at the buffer depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                r_fill <= '0;
    else if (w_wr_en && (r_fill != FILL_MAX)) r_fill <= r_fill + 1'b1;
  end

  // Validity flag: captured on the same edge the RAM read register loads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    r_dout_valid <= 1'b0;
    else if (en) r_dout_valid <= w_rd_ok;
  end

  // RAM read register and validity flag both hold between strobes, so the
  // gated output holds too; invalid reads never expose uninitialised RAM.
  assign dout       = r_dout_valid ? w_rdata : '0;
  assign dout_valid = r_dout_valid;
  assign full       = (r_fill == FILL_MAX);

endmodule

// File: tb/tb_sigcapture.sv
// tb_sigcapture: randomized + directed self-checking bench for sigcapture
// (A_WIDTH=4, D_WIDTH=8) against a sample-history reference model.
module tb_sigcapture;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [DW-1:0] din;
  logic [AW-1:0] offset;
`ifdef SIGCAPTURE_FREEZE_EN
  logic          freeze;
`endif
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          full;

  int checks = 0;
  int errors = 0;
  bit done   = 0;

  // Reference model: hist holds, for each of the last N strobes, what that
  // strobe's buffer slot contains; a read with delay d sees hist[size-d].
  logic [DW-1:0] hist[$];
  int            m_fill  = 0;
  logic [DW-1:0] m_dout  = '0;
  logic          m_valid = 1'b0;

  sigcapture #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .din        (din),
    .offset     (offset),
`ifdef SIGCAPTURE_FREEZE_EN
    .freeze     (freeze),
`endif
    .dout       (dout),
    .dout_valid (dout_valid),
    .full       (full)
  );

  always #5 clk = ~clk;

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!done) begin
      checks++;
      if (dout !== m_dout || dout_valid !== m_valid || full !== (m_fill == N)) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t got dout=%h v=%b full=%b want dout=%h v=%b full=%b",
                 $time, dout, dout_valid, full, m_dout, m_valid, (m_fill == N));
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_fill  = 0;
    m_dout  = '0;
    m_valid = 1'b0;
  endtask

  // Apply one cycle of inputs, advance the clock, then update the model.
  task automatic step(input logic e, input logic [DW-1:0] d, input logic [AW-1:0] off,
                      input logic frz);
    int            dd;
    int            sz;
    logic [DW-1:0] nd;
    logic          nv;
    logic [DW-1:0] slot;
    en = e; din = d; offset = off;
`ifdef SIGCAPTURE_FREEZE_EN
    freeze = frz;
`endif
    nd = m_dout; nv = m_valid;
    sz = hist.size();
    slot = d;
    if (e) begin
      dd = (off == 0) ? N : int'(off);
      if (dd <= m_fill && dd <= sz) begin nd = hist[sz-dd]; nv = 1'b1; end
      else begin nd = '0; nv = 1'b0; end
      if (frz) slot = (sz >= N) ? hist[sz-N] : '0;
    end
    @(posedge clk); #1;
    m_dout = nd; m_valid = nv;
    if (e) begin
      hist.push_back(slot);
      if (hist.size() > N) void'(hist.pop_front());
      if (!frz && m_fill < N) m_fill++;
    end
  endtask

  // Mid-cycle asynchronous reset, released just after a rising edge.
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("rst_dout", int'(dout), 0);
    chk("rst_valid", int'(dout_valid), 0);
    chk("rst_full", int'(full), 0);
    @(posedge clk); #1 rst = 1'b1;
  endtask

  initial begin
    logic [AW-1:0] roff;
    rst = 1'b0; en = 1'b0; din = '0; offset = '0;
`ifdef SIGCAPTURE_FREEZE_EN
    freeze = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("init_dout", int'(dout), 0);
    chk("init_valid", int'(dout_valid), 0);
    chk("init_full", int'(full), 0);
    rst = 1'b1;

    // Ramp with delay 3.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, DW'(i), 4'd3, 1'b0);
      if (i == 2)  chk("ramp_valid_s3", int'(dout_valid), 0);
      if (i == 3)  begin chk("ramp_valid_s4", int'(dout_valid), 1); chk("ramp_dout_s4", int'(dout), 0); end
      if (i == 10) chk("ramp_dout_10", int'(dout), 7);
    end

    // Reset mid-stream, then validity restarts from zero.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, DW'(8'hA0 + i), 4'd3, 1'b0);
      if (i < 3) chk("post_rst_invalid", int'(dout_valid), 0);
    end

    // Offset 0 / full.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(1'b1, DW'(8'h10 + i), 4'd0, 1'b0);
      if (i == 14) chk("full_s15", int'(full), 0);
      if (i == 15) chk("full_s16", int'(full), 1);
      if (i == 16) begin chk("lap_dout", int'(dout), 8'h10); chk("lap_valid", int'(dout_valid), 1); end
    end

    // Wrap with delay 5.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step(1'b1, DW'(i * 3 + 1), 4'd5, 1'b0);
      if (i >= 5) chk("wrap_dout", int'(dout), ((i - 5) * 3 + 1) & 8'hFF);
    end

    // Gaps: en pattern 1,0,0,1; delay counts strobes.
    for (int i = 0; i < 24; i++)
      step(((i % 4) == 0) || ((i % 4) == 3), DW'(8'h40 + i), 4'd2, 1'b0);
    chk("gap_hold", int'(dout_valid), 1);

`ifdef SIGCAPTURE_FREEZE_EN
    // Freeze: capture 0..15 then replay with writes suppressed.
    do_reset();
    for (int i = 0; i < N; i++) step(1'b1, DW'(i), 4'd0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 8'hFF, 4'd0, 1'b1);
      chk("freeze_dout", int'(dout), k % N);
    end
`endif

    // Randomized traffic, one reset in the middle.
    roff = 4'd7;
    for (int i = 0; i < 600; i++) begin
      logic e;
      logic frz;
      if (i == 300) do_reset();
      if ($urandom_range(0, 15) == 0) roff = AW'($urandom);
      e = ($urandom_range(0, 9) < 7);
      frz = 1'b0;
`ifdef SIGCAPTURE_FREEZE_EN
      frz = (m_fill == N) && ($urandom_range(0, 3) == 0);
`endif
      step(e, DW'($urandom), roff, frz);
    end

    @(negedge clk);
    done = 1;
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sigcapture.md
# sigcapture

Circular-buffer sample recorder that is the write-side counterpart of the sine generator's ROM read path. It accepts a stream of `D_WIDTH`-bit samples (the generator's output or an external ADC stream) and stores them in a dual-port RAM. On every sample it reads back a copy delayed by a programmable `offset`. It sits between the signal source and the display/DAC path, and provides delay lines and snapshot replay.

## Interface
- `A_WIDTH`, 9, address width; buffer depth is 2^A_WIDTH samples.
- `D_WIDTH`, 8, sample width.

- `clk`  in  1  single clock; all state on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; deasserted synchronously by upstream logic.
- `en`  in  1  sample strobe; one sample is accepted per cycle that `en`=1.
- `din`  in  D_WIDTH  input sample, sampled when `en`=1.
- `offset`  in  A_WIDTH  delay in samples; 0 means a delay of 2^A_WIDTH.
- `dout`  out  D_WIDTH  delayed sample, registered.
- `dout_valid`  out  1  `dout` holds real recorded data.
- `full`  out  1  buffer has been completely written at least once since reset.

## Operation
- State:
  - `wr_addr` is a free-running A_WIDTH counter.
  - `fill` is an (A_WIDTH+1)-bit counter that saturates at 2^A_WIDTH.
- On each cycle with `en`=1:
  - Write `din` to RAM[`wr_addr`].
  - Read RAM[(`wr_addr` − `offset`) mod 2^A_WIDTH].
  - Increment `wr_addr`, wrapping from 2^A_WIDTH−1 to 0.
  - Increment `fill` unless it is already saturated.
- Effective delay: `d = (offset==0) ? 2^A_WIDTH : offset`.
- Read-during-write to the same address (offset=0) returns the old contents, i.e. the sample written 2^A_WIDTH strobes earlier.
- Validity: the read is valid iff `d ≤ fill`, evaluated against `fill` before the increment.
  - Valid read: `dout` ← RAM data, `dout_valid` ← 1.
  - Invalid read: `dout` ← 0, `dout_valid` ← 0.
- `full` = (`fill` == 2^A_WIDTH).
- Cycles with `en`=0: no write, no counter change; `dout` and `dout_valid` hold.
- `offset` may change at any time. The new value applies to the next strobe; there is no smoothing.
- Arithmetic: the address subtraction is modulo 2^A_WIDTH. `fill` comparison is unsigned at A_WIDTH+1 bits.
- RAM contents are not reset. Validity gating guarantees no uninitialised data reaches `dout`.

## Timing
- Reset (`rst`=0, asynchronous) forces:
  - `wr_addr`=0, `fill`=0
  - `dout`=0, `dout_valid`=0, `full`=0
- A reset mid-stream discards all history. Validity restarts from zero even though RAM still holds old data.
- Latency: `dout`/`dout_valid` update on the same edge that writes `din`. They are visible one cycle after the `en` cycle and hold until the next strobe.
- Back-to-back `en` sustains one sample per cycle with no stalls.
- `full` rises on the edge of the 2^A_WIDTH-th accepted strobe and stays high until reset.

## Configuration
- `SIGCAPTURE_FREEZE_EN` defined: adds input port `freeze` (1 bit). While `freeze`=1 during an `en` strobe:
  - RAM write and `fill` increment are suppressed.
  - `wr_addr` still advances and reads proceed normally.
  - The frozen buffer therefore replays cyclically with period 2^A_WIDTH strobes.
- Macro undefined: there is no `freeze` port, and every strobe writes.

## Structure
- Package `sigcapture_pkg`:
  - default `A_WIDTH`/`D_WIDTH` localparams
  - `DEPTH` = 2^A_WIDTH
  - a typedef for the fill counter width
- Sub-module `ram2port`:
  - one synchronous write port and one synchronous read port on `clk`
  - read-old-on-collision
  - parameterised by A_WIDTH/D_WIDTH
- Top level holds the counters, the validity compare and the output registers.

## Test plan
All scenarios use A_WIDTH=4, D_WIDTH=8.
- Reset: drive `rst`=0 mid-stream → `dout`=0, `dout_valid`=0, `full`=0 immediately. After release with offset=3, the first 3 strobes give `dout_valid`=0.
- Ramp delay: `din`=0,1,2,… each cycle with `en`=1, offset=3 → from the 4th strobe `dout_valid`=1 and `dout` = `din`−3 (e.g. strobe with `din`=10 gives `dout`=7).
- Offset 0 / full: 16 strobes of `din`=0x10..0x1F → `full` rises after the 16th, and the 17th strobe returns `dout`=0x10.
- Wrap: offset=5, run 40 strobes → `dout` = `din`−5 across the `wr_addr` 15→0 wrap, with no glitch.
- Gaps: `en` toggled 1,0,0,1 → `dout` holds through idle cycles, and delay counts strobes, not cycles.
- Freeze (with `SIGCAPTURE_FREEZE_EN`): fill with 0..15, assert `freeze` while driving `din`=0xFF, offset=0 → `dout` cycles 0..15 repeatedly and never shows 0xFF.
